// File: rtl/mainfsm_pkg.sv
// Shared encodings for the mainfsm_ws multicycle controller: states,
// datapath mux selects, opcode classes and the decoded control bundle.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        BRLINK   = 4'd10,
        MULEX    = 4'd11,
        MULWB    = 4'd12,
        UNDEF    = 4'd13,
        FAULT    = 4'd14
    } state_t;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] SRCB_ZERO  = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_PROD   = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       linkw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       mulstart;
        logic       undef;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_ws_if.sv
// Instruction/handshake inputs and datapath control outputs of mainfsm_ws.
// master = controller side, slave = datapath side.
interface mainfsm_ws_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MulInstr;
    logic       MemReady;

    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       LinkW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       MulStart;
    logic       Undef;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Op, Funct, MulInstr, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               LinkW, MemW, Branch, ALUOp, MulStart, Undef, Fault, State
    );

    modport slave (
        output Op, Funct, MulInstr, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               LinkW, MemW, Branch, ALUOp, MulStart, Undef, Fault, State
    );

endinterface

// File: rtl/mainfsm_ws_out.sv
// Combinational state-to-control decoder for mainfsm_ws.
// FAULT decoding exists only when MAINFSM_MEM_TIMEOUT_EN is defined.
module mainfsm_ws_out
    import mainfsm_pkg::*;
(
    input  state_t state,
    input  logic   first,
    input  logic   memready,
    input  logic   reset,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURES;
                // Memory-qualified enables are also masked by reset so nothing
                // is committed while the sequence is being aborted.
                ctrl.irwrite   = memready & ~reset;
                ctrl.nextpc    = memready & ~reset;
            end
            DECODE: begin
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURES;
            end
            EXECUTER: begin
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = 1'b1;
            end
            ALUWB: begin
                ctrl.regw      = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            MEMADR: ctrl.alusrcb = SRCB_IMM;
            MEMRD:  ctrl.adrsrc  = 1'b1;
            MEMWB: begin
                ctrl.regw      = 1'b1;
                ctrl.resultsrc = RES_DATA;
            end
            MEMWR: begin
                ctrl.adrsrc = 1'b1;
                ctrl.memw   = ~reset;
            end
            BRLINK: begin
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_ZERO;
                ctrl.resultsrc = RES_ALURES;
                ctrl.regw      = 1'b1;
                ctrl.linkw     = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca   = SRCA_REG;
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALURES;
                ctrl.branch    = 1'b1;
            end
            MULEX: ctrl.mulstart = first;
            MULWB: begin
                ctrl.regw      = 1'b1;
                ctrl.resultsrc = RES_PROD;
            end
            UNDEF: ctrl.undef = 1'b1;
`ifdef MAINFSM_MEM_TIMEOUT_EN
            FAULT: ctrl.fault = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mainfsm_ws.sv
// Main multicycle control FSM with memory wait handshake, BL, multi-cycle MUL
// and undefined-instruction trap. Optional MAINFSM_MEM_TIMEOUT_EN adds FAULT.
module mainfsm_ws
    import mainfsm_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input logic          clk,
    input logic          reset,
    mainfsm_ws_if.master bus
);

`ifdef MAINFSM_MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             first;
    ctrl_t            ctrl;
    logic             unused_funct;

    assign unused_funct = ^bus.Funct[3:1];
    assign first        = (cnt == CNT_ONE);

    // Counter clears by default; only wait states and MULEX keep counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            cnt <= '0;
            case (state)
                FETCH, MEMRD, MEMWR: begin
                    if (bus.MemReady) begin
                        if (state == FETCH)      state <= DECODE;
                        else if (state == MEMRD) state <= MEMWB;
                        else                     state <= FETCH;
                    end else if (TMO_EN && cnt >= TMO_LAST) begin
                        state <= FAULT;
                    end else if (TMO_EN) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DECODE: begin
                    case (bus.Op)
                        OP_DP: begin
                            if (bus.MulInstr) begin
                                state <= MULEX;
                                cnt   <= CNT_ONE;
                            end else if (bus.Funct[5]) begin
                                state <= EXECUTEI;
                            end else begin
                                state <= EXECUTER;
                            end
                        end
                        OP_MEM:  state <= MEMADR;
                        OP_BR:   state <= bus.Funct[4] ? BRLINK : BRANCH;
                        default: state <= UNDEF;
                    endcase
                end
                EXECUTER, EXECUTEI: state <= ALUWB;
                MEMADR:  state <= bus.Funct[0] ? MEMRD : MEMWR;
                BRLINK:  state <= BRANCH;
                MULEX: begin
                    if (cnt >= MUL_LAST) state <= MULWB;
                    else                 cnt   <= cnt + CNT_ONE;
                end
                FAULT:   state <= TMO_EN ? FAULT : FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    mainfsm_ws_out u_out (
        .state    (state),
        .first    (first),
        .memready (bus.MemReady),
        .reset    (reset),
        .ctrl     (ctrl)
    );

    assign bus.IRWrite   = ctrl.irwrite;
    assign bus.AdrSrc    = ctrl.adrsrc;
    assign bus.ALUSrcA   = ctrl.alusrca;
    assign bus.ALUSrcB   = ctrl.alusrcb;
    assign bus.ResultSrc = ctrl.resultsrc;
    assign bus.NextPC    = ctrl.nextpc;
    assign bus.RegW      = ctrl.regw;
    assign bus.LinkW     = ctrl.linkw;
    assign bus.MemW      = ctrl.memw;
    assign bus.Branch    = ctrl.branch;
    assign bus.ALUOp     = ctrl.aluop;
    assign bus.MulStart  = ctrl.mulstart;
    assign bus.Undef     = ctrl.undef;
    assign bus.Fault     = ctrl.fault;
    assign bus.State     = state;

endmodule

// File: tb/tb_mainfsm_ws.sv
// Scoreboard bench for mainfsm_ws: random instruction streams are expanded into
// per-cycle expected control rows; a monitor pops and compares every cycle.
module tb_mainfsm_ws;
    import mainfsm_pkg::*;

    localparam int MC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mainfsm_ws_if bus ();
    mainfsm_ws_if bus1 ();

    mainfsm_ws #(.MUL_CYCLES(MC), .MEM_TIMEOUT(15), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mainfsm_ws #(.MUL_CYCLES(1), .MEM_TIMEOUT(15), .CNT_W(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic       mul;
        logic       rdy;
        logic [3:0] st;
        logic       irw, adr;
        logic [1:0] sa, sb, rs;
        logic       npc, rw, lw, memw, br, aop, ms, ud, ft;
    } cyc_t;

    cyc_t plan[$];
    cyc_t exp_q[$];
    cyc_t e;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;
    logic       cur_mul;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned ncyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cyc_t base(input state_t st, input logic rdy);
        cyc_t c;
        c = '{default: '0};
        c.op = cur_op; c.funct = cur_funct; c.mul = cur_mul;
        c.rdy = rdy; c.st = st;
        return c;
    endfunction

    function automatic cyc_t fetch_row(input logic rdy);
        cyc_t c;
        c = base(FETCH, rdy);
        c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10;
        c.irw = rdy; c.npc = rdy;
        return c;
    endfunction

    // kind: 0 DP reg, 1 DP imm, 2 LDR, 3 STR, 4 B, 5 BL, 6 MUL, 7 undefined
    task automatic p_instr(input int kind, input int unsigned fw, input int unsigned mwait);
        cyc_t c;
        cur_funct = 6'($urandom);
        cur_mul   = 1'b0;
        case (kind)
            0: begin cur_op = 2'b00; cur_funct[5] = 1'b0; end
            1: begin cur_op = 2'b00; cur_funct[5] = 1'b1; end
            2: begin cur_op = 2'b01; cur_funct[0] = 1'b1; end
            3: begin cur_op = 2'b01; cur_funct[0] = 1'b0; end
            4: begin cur_op = 2'b10; cur_funct[4] = 1'b0; end
            5: begin cur_op = 2'b10; cur_funct[4] = 1'b1; end
            6: begin cur_op = 2'b00; cur_mul = 1'b1; end
            default: begin cur_op = 2'b11; cur_mul = 1'($urandom); end
        endcase
        for (int unsigned i = 0; i <= fw; i++) plan.push_back(fetch_row(i == fw));
        c = base(DECODE, 1'($urandom));
        c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10;
        plan.push_back(c);
        case (kind)
            0, 1: begin
                c = base(kind == 0 ? EXECUTER : EXECUTEI, 1'($urandom));
                c.sb = (kind == 0) ? 2'b00 : 2'b01; c.aop = 1'b1;
                plan.push_back(c);
                c = base(ALUWB, 1'($urandom)); c.rw = 1'b1; c.rs = 2'b00;
                plan.push_back(c);
            end
            2, 3: begin
                c = base(MEMADR, 1'($urandom)); c.sb = 2'b01;
                plan.push_back(c);
                for (int unsigned i = 0; i <= mwait; i++) begin
                    c = base(kind == 2 ? MEMRD : MEMWR, i == mwait);
                    c.adr = 1'b1; c.memw = (kind == 3);
                    plan.push_back(c);
                end
                if (kind == 2) begin
                    c = base(MEMWB, 1'($urandom)); c.rw = 1'b1; c.rs = 2'b01;
                    plan.push_back(c);
                end
            end
            4, 5: begin
                if (kind == 5) begin
                    c = base(BRLINK, 1'($urandom));
                    c.sa = 2'b01; c.sb = 2'b11; c.rs = 2'b10; c.rw = 1'b1; c.lw = 1'b1;
                    plan.push_back(c);
                end
                c = base(BRANCH, 1'($urandom));
                c.sa = 2'b00; c.sb = 2'b01; c.rs = 2'b10; c.br = 1'b1;
                plan.push_back(c);
            end
            6: begin
                for (int i = 0; i < MC; i++) begin
                    c = base(MULEX, 1'($urandom)); c.ms = (i == 0);
                    plan.push_back(c);
                end
                c = base(MULWB, 1'($urandom)); c.rw = 1'b1; c.rs = 2'b11;
                plan.push_back(c);
            end
            default: begin
                c = base(UNDEF, 1'($urandom)); c.ud = 1'b1;
                plan.push_back(c);
            end
        endcase
    endtask

    task automatic run_plan();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            bus.Op = c.op; bus.Funct = c.funct; bus.MulInstr = c.mul; bus.MemReady = c.rdy;
            exp_q.push_back(c);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("cyc%0d_state", ncyc), 32'(bus.State), 32'(e.st));
            chk($sformatf("cyc%0d_ctrl", ncyc),
                32'({bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                     bus.NextPC, bus.RegW, bus.LinkW, bus.MemW, bus.Branch, bus.ALUOp,
                     bus.MulStart, bus.Undef, bus.Fault}),
                32'({e.irw, e.adr, e.sa, e.sb, e.rs, e.npc, e.rw, e.lw, e.memw,
                     e.br, e.aop, e.ms, e.ud, e.ft}));
            ncyc++;
        end
    end

    initial begin : mul1_chk
        state_t seq [4];
        seq = '{FETCH, DECODE, MULEX, MULWB};
        bus1.Op = 2'b00; bus1.Funct = 6'b100000; bus1.MulInstr = 1'b1; bus1.MemReady = 1'b1;
        @(negedge reset);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #2;
            chk($sformatf("mul1_state%0d", i), 32'(bus1.State), 32'(seq[(i + 1) % 4]));
            chk($sformatf("mul1_start%0d", i), 32'(bus1.MulStart), 32'((i + 1) % 4 == 2));
            chk($sformatf("mul1_regw%0d", i), 32'(bus1.RegW), 32'((i + 1) % 4 == 3));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.Op = 2'b00; bus.Funct = '0; bus.MulInstr = 1'b0; bus.MemReady = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_state", 32'(bus.State), 32'(FETCH));
        chk("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        chk("rst_nextpc", 32'(bus.NextPC), 32'd0);
        chk("rst_memw", 32'(bus.MemW), 32'd0);
        chk("rst_fault", 32'(bus.Fault), 32'd0);
        reset = 1'b0; bus.MemReady = 1'b0;

        // Directed test-plan cases first, then a random stream.
        p_instr(0, 0, 0);
        p_instr(2, 1, 3);
        p_instr(3, 0, 2);
        p_instr(5, 2, 0);
        p_instr(6, 0, 0);
        p_instr(7, 0, 0);
        for (int i = 0; i < 60; i++)
            p_instr(int'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 4));
        // Store left waiting so reset can abort it mid-write.
        cur_op = 2'b01; cur_funct = 6'b000000; cur_mul = 1'b0;
        plan.push_back(fetch_row(1'b1));
        e = base(DECODE, 1'b0); e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10;
        plan.push_back(e);
        e = base(MEMADR, 1'b0); e.sb = 2'b01;
        plan.push_back(e);
        for (int i = 0; i < 2; i++) begin
            e = base(MEMWR, 1'b0); e.adr = 1'b1; e.memw = 1'b1;
            plan.push_back(e);
        end
        run_plan();

        @(negedge clk);
        bus.MemReady = 1'b0;
        #3;
        chk("abort_memw_held", 32'(bus.MemW), 32'd1);
        chk("abort_state_memwr", 32'(bus.State), 32'(MEMWR));
        bus.MemReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("abort_memw_drop", 32'(bus.MemW), 32'd0);
        chk("abort_state_fetch", 32'(bus.State), 32'(FETCH));
        chk("abort_irwrite", 32'(bus.IRWrite), 32'd0);
        #2;
        reset = 1'b0; bus.MemReady = 1'b0;

        p_instr(0, 0, 0);
`ifdef MAINFSM_MEM_TIMEOUT_EN
        cur_op = 2'b00; cur_funct = '0; cur_mul = 1'b0;
        for (int i = 0; i < 16; i++) plan.push_back(fetch_row(1'b0));
        for (int i = 0; i < 4; i++) begin
            e = base(FAULT, 1'($urandom)); e.ft = 1'b1;
            plan.push_back(e);
        end
`else
        p_instr(0, 20, 0);
`endif
        run_plan();

        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("final_rst_state", 32'(bus.State), 32'(FETCH));
        chk("final_rst_fault", 32'(bus.Fault), 32'd0);
        #2;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mainfsm_ws.md
Name: mainfsm_ws

Overview:
Next-generation main control FSM for the multicycle ARM processor. Adds a memory ready/wait handshake on every memory cycle and a branch-with-link (BL) path. It also adds a multi-cycle multiply sequence with a parametrised latency and explicit handling of undefined instructions. It sits in the controller alongside the ALU decoder and condition logic, and drives the datapath muxes and enables each cycle.

Parameters:
MUL_CYCLES, 4, cycles spent in MULEX before writeback (legal range 1..15)
MEM_TIMEOUT, 15, wait cycles tolerated without MemReady before faulting (used only with the optional feature)
CNT_W, 4, width of the shared internal cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
Op  in  2  instr[27:26]
Funct  in  6  instr[25:20]; for branches Funct[4] is the L bit
MulInstr  in  1  decoder flag: current instruction is MUL
MemReady  in  1  memory completes the current access this cycle
IRWrite  out  1  instruction register load enable
AdrSrc  out  1  0=PC, 1=ALUOut
ALUSrcA  out  2  00=RegA, 01=PC
ALUSrcB  out  2  00=RegB, 01=ExtImm, 10=const 4, 11=zero
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=product
NextPC  out  1  PC update enable
RegW  out  1  register write
LinkW  out  1  forces register write address to R14
MemW  out  1  memory write
Branch  out  1  conditional PC load
ALUOp  out  1  1=ALU decoder drives the ALU, 0=ADD
MulStart  out  1  one-cycle multiplier start pulse
Undef  out  1  one-cycle undefined-instruction pulse
Fault  out  1  memory timeout (sticky)
State  out  4  current state, for debug

Behaviour:
- reset: state=FETCH, counter=0, Fault=0. IRWrite, NextPC and MemW are forced to 0 while reset is high.
- Outputs are Moore-decoded from the state, except IRWrite, NextPC and MemW, which are qualified by MemReady as stated below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - IRWrite = NextPC = MemReady.
  - Stays in FETCH while !MemReady; goes to DECODE on MemReady.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Next state by priority:
    - Op=00 & MulInstr -> MULEX
    - Op=00 & Funct[5] -> EXECUTEI
    - Op=00 -> EXECUTER
    - Op=01 -> MEMADR
    - Op=10 & Funct[4] -> BRLINK
    - Op=10 -> BRANCH
    - Op=11 -> UNDEF
- EXECUTER: ALUSrcB=00, ALUOp=1; goes to ALUWB.
- EXECUTEI: ALUSrcB=01, ALUOp=1; goes to ALUWB.
- ALUWB: RegW=1, ResultSrc=00; goes to FETCH.
- MEMADR: ALUSrcB=01; goes to MEMRD if Funct[0], else MEMWR.
- MEMRD: AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: RegW=1, ResultSrc=01; goes to FETCH.
- MEMWR: AdrSrc=1. MemW=1 is held every cycle until the cycle MemReady=1, then FETCH. Only one write completes.
- BRLINK: ALUSrcA=01, ALUSrcB=11, ResultSrc=10, RegW=1, LinkW=1. This writes LR = PC, which already holds branch+4. Goes to BRANCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1; goes to FETCH.
- MULEX:
  - MulStart=1 on the entry cycle only; the counter loads 1 on entry.
  - Stays while counter < MUL_CYCLES, incrementing each cycle; goes to MULWB when counter = MUL_CYCLES.
  - MUL_CYCLES=1 gives a single MULEX cycle.
- MULWB: RegW=1, ResultSrc=11; goes to FETCH.
- UNDEF: Undef=1 for 1 cycle, no register or memory writes; goes to FETCH.
- Illegal state encodings go to FETCH.
- The counter is cleared on every state change.
- An asynchronous reset in any state, including mid-wait or mid-multiply, aborts the sequence. MemW drops in the same cycle.

Optional Feature:
MAINFSM_MEM_TIMEOUT_EN
- Defined:
  - In FETCH, MEMRD and MEMWR, the counter increments on each !MemReady cycle.
  - On the cycle the counter would exceed MEM_TIMEOUT, the FSM goes to FAULT.
  - FAULT: all enables 0, Fault=1; it is absorbing until reset.
- Undefined: the FSM waits indefinitely, Fault is tied to 0 and the FAULT state is not generated.

Decomposition:
- Package mainfsm_pkg holds:
  - the state encodings: FETCH..MULWB, UNDEF, FAULT
  - the ALUSrcA, ALUSrcB and ResultSrc encoding constants
  - the Op constants: DP=00, MEM=01, BR=10
- One natural sub-module, mainfsm_ws_out: the purely combinational state-to-control decoder. The parent keeps the state register, counter and next-state logic.

Test Plan:
- ADD R1,R2,R3 with MemReady tied 1 -> FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in cycle 4; IRWrite=1 only in cycle 1.
- LDR with MemReady low for 3 cycles in MEMRD -> 3 extra MEMRD cycles, then MEMWB with ResultSrc=01, RegW=1.
- STR with MemReady low for 2 cycles -> MemW=1 for exactly 3 consecutive cycles, then FETCH.
- BL (Op=10, Funct[4]=1) -> BRLINK with LinkW=1, RegW=1, ALUSrcB=11, then BRANCH with Branch=1.
- MUL with MUL_CYCLES=4 -> one MulStart pulse, 4 MULEX cycles, MULWB with ResultSrc=11; repeat with MUL_CYCLES=1 -> 1 MULEX cycle.
- Op=11 -> Undef pulses 1 cycle then FETCH. With MAINFSM_MEM_TIMEOUT_EN and MEM_TIMEOUT=15, MemReady stuck low in FETCH -> Fault=1 after the 16th wait cycle and stays 1 until reset.
